ctrl_sequencer: RTL and testbench

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

---
 rtl/ctrl_sequencer_pkg.sv | 34 +++
 rtl/ctrl_sequencer.sv | 104 ++++++++++
 tb/tb_ctrl_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the control sequencer and the output-signal decoder.
// Step codes, opcode constants and instruction field positions live here.
package ctrl_sequencer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00000,
    ST_LOAD     = 5'b00001,
    ST_MOV      = 5'b00010,
    ST_ARITH_A  = 5'b00011,
    ST_ARITH_B  = 5'b00100,
    ST_ARITH_WB = 5'b00101,
    ST_HALT     = 5'b00110
  } state_e;

  localparam logic [2:0] OPC_LOAD = 3'b000;
  localparam logic [2:0] OPC_MOV  = 3'b001;
  localparam logic [2:0] OPC_ADD  = 3'b010;
  localparam logic [2:0] OPC_SUB  = 3'b011;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // Instruction field bit positions: [22:20] opcode, [19:16] Rx, [15:12] Ry
  localparam int OPC_MSB = 22;
  localparam int OPC_LSB = 20;
  localparam int RX_MSB  = 19;
  localparam int RX_LSB  = 16;
  localparam int RY_MSB  = 15;
  localparam int RY_LSB  = 12;

  // True for the two opcodes that run the three-step arithmetic sequence
  function automatic logic is_arith(input logic [2:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

endpackage

// File: rtl/ctrl_sequencer.sv
// Instruction control sequencer: accepts one instruction at a time from IDLE,
// walks it through its execution steps and counts retired instructions.
// Optional build macro CTRL_SEQ_HALT_EN: opcode 111 enters a sticky HALT
// state (left only by rst); without it opcode 111 is treated as illegal.
module ctrl_sequencer #(
  parameter int INSTR_W = 23,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [INSTR_W-1:0] instr_q,
  output logic [4:0]         state,
  output logic               alu_sub,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  import ctrl_sequencer_pkg::*;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_lat_q, instr_lat_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic [2:0]         opc_in;
  logic [2:0]         opc_lat;

  assign opc_in      = instr[OPC_MSB:OPC_LSB];
  assign opc_lat     = instr_lat_q[OPC_MSB:OPC_LSB];

  assign instr_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_LOAD) || (state_q == ST_MOV) ||
                       (state_q == ST_ARITH_WB);
  assign alu_sub     = (state_q == ST_ARITH_B) && (opc_lat == OPC_SUB);
  assign state       = state_q;
  assign instr_q     = instr_lat_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

  // Next-state, instruction latch and illegal-pulse decode
  always_comb begin
    state_d     = state_q;
    instr_lat_d = instr_lat_q;
    illegal_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (opc_in == OPC_LOAD) begin
            state_d     = ST_LOAD;
            instr_lat_d = instr;
          end else if (opc_in == OPC_MOV) begin
            state_d     = ST_MOV;
            instr_lat_d = instr;
          end else if (is_arith(opc_in)) begin
            state_d     = ST_ARITH_A;
            instr_lat_d = instr;
`ifdef CTRL_SEQ_HALT_EN
          end else if (opc_in == OPC_HALT) begin
            state_d     = ST_HALT;
            instr_lat_d = instr;
`endif
          end else begin
            // Unsupported opcode: stay in IDLE, keep the latched instruction
            illegal_d   = 1'b1;
          end
        end
      end
      ST_LOAD, ST_MOV, ST_ARITH_WB: state_d = ST_IDLE;
      ST_ARITH_A:                   state_d = ST_ARITH_B;
      ST_ARITH_B:                   state_d = ST_ARITH_WB;
`ifdef CTRL_SEQ_HALT_EN
      ST_HALT:                      state_d = ST_HALT;
`else
      ST_HALT:                      state_d = ST_IDLE;
`endif
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Retired counter advances at the edge that ends every done step
  always_comb begin
    retired_d = retired_q;
    if (done) retired_d = retired_q + CNT_W'(1);
  end

  // State registers; reset abandons any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_lat_q <= '0;
      retired_q   <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_lat_q <= instr_lat_d;
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: reset checks, a table of directed
// vectors, and hand-written sequences for async reset, counter wrap and
// opcode 111 (HALT or illegal depending on CTRL_SEQ_HALT_EN).
// The counter is built narrow (CNT_W=8) so its wrap is reached quickly.
module tb_ctrl_sequencer;
  import ctrl_sequencer_pkg::*;

  localparam int IW = 23;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic [IW-1:0] instr_q;
  logic [4:0]    state;
  logic          alu_sub;
  logic          done;
  logic          illegal;
  logic [CW-1:0] retired;

  ctrl_sequencer #(.INSTR_W(IW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .instr_q     (instr_q),
    .state       (state),
    .alu_sub     (alu_sub),
    .done        (done),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [IW-1:0] ins;
    logic [4:0]    st;
    logic          rdy;
    logic          dn;
    logic          sub;
    logic          ill;
    logic [CW-1:0] ret;
    logic [IW-1:0] iq;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  int n_vec = 0;
  int n_err = 0;
  int exp_ret;

  logic [IW-1:0] I_LD, I_SUB, I_MOV, I_ADD, I_B4, I_B5, I_B6, I_B7;

  function automatic logic [IW-1:0] mk(input logic [2:0] o, input logic [3:0] x,
                                       input logic [3:0] y);
    logic [IW-1:0] w;
    w = '0;
    w[OPC_MSB:OPC_LSB] = o;
    w[RX_MSB:RX_LSB]   = x;
    w[RY_MSB:RY_LSB]   = y;
    return w;
  endfunction

  task automatic setv(input int i, input logic vld, input logic [IW-1:0] ins,
                      input logic [4:0] st, input logic rdy, input logic dn,
                      input logic sub, input logic ill, input logic [CW-1:0] ret,
                      input logic [IW-1:0] iq);
    vt[i].vld = vld; vt[i].ins = ins; vt[i].st = st; vt[i].rdy = rdy;
    vt[i].dn = dn; vt[i].sub = sub; vt[i].ill = ill; vt[i].ret = ret;
    vt[i].iq = iq;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    I_LD  = mk(3'b000, 4'd3, 4'd0);
    I_SUB = mk(3'b011, 4'd2, 4'd5);
    I_MOV = mk(3'b001, 4'd1, 4'd4);
    I_ADD = mk(3'b010, 4'd6, 4'd7);
    I_B4  = mk(3'b100, 4'd0, 4'd0);
    I_B5  = mk(3'b101, 4'd1, 4'd1);
    I_B6  = mk(3'b110, 4'd2, 4'd2);
    I_B7  = mk(3'b111, 4'd3, 4'd3);

    //      i  vld ins    st        rdy dn sub ill ret  iq
    setv( 0, 1, I_SUB, 5'b00011, 0, 0, 0, 0, 8'd1, I_SUB);
    setv( 1, 1, I_MOV, 5'b00100, 0, 0, 1, 0, 8'd1, I_SUB);
    setv( 2, 1, I_MOV, 5'b00101, 0, 1, 0, 0, 8'd1, I_SUB);
    setv( 3, 1, I_MOV, 5'b00000, 1, 0, 0, 0, 8'd2, I_SUB);
    setv( 4, 1, I_MOV, 5'b00010, 0, 1, 0, 0, 8'd2, I_MOV);
    setv( 5, 0, I_MOV, 5'b00000, 1, 0, 0, 0, 8'd3, I_MOV);
    setv( 6, 1, I_ADD, 5'b00011, 0, 0, 0, 0, 8'd3, I_ADD);
    setv( 7, 0, I_ADD, 5'b00100, 0, 0, 0, 0, 8'd3, I_ADD);
    setv( 8, 0, I_ADD, 5'b00101, 0, 1, 0, 0, 8'd3, I_ADD);
    setv( 9, 0, I_ADD, 5'b00000, 1, 0, 0, 0, 8'd4, I_ADD);
    setv(10, 1, I_B4,  5'b00000, 1, 0, 0, 1, 8'd4, I_ADD);
    setv(11, 1, I_B5,  5'b00000, 1, 0, 0, 1, 8'd4, I_ADD);
    setv(12, 1, I_B6,  5'b00000, 1, 0, 0, 1, 8'd4, I_ADD);
    setv(13, 0, I_B6,  5'b00000, 1, 0, 0, 0, 8'd4, I_ADD);
    setv(14, 1, I_LD,  5'b00001, 0, 1, 0, 0, 8'd4, I_LD);
    setv(15, 0, I_LD,  5'b00000, 1, 0, 0, 0, 8'd5, I_LD);

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(state),       32'd0);
    chk("rst_ready",   32'(instr_ready), 32'd1);
    chk("rst_retired", 32'(retired),     32'd0);
    chk("rst_illegal", 32'(illegal),     32'd0);
    chk("rst_instr_q", 32'(instr_q),     32'd0);
    chk("rst_done",    32'(done),        32'd0);
    rst = 1'b0;

    // Async reset while in ARITH_B, then first handshake right after release
    instr_valid = 1'b1; instr = I_SUB;
    step();
    instr_valid = 1'b0;
    step();
    chk("pre_rst_state", 32'(state),   32'b00100);
    chk("pre_rst_sub",   32'(alu_sub), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_state",   32'(state),       32'd0);
    chk("async_rst_retired", 32'(retired),     32'd0);
    chk("async_rst_instr_q", 32'(instr_q),     32'd0);
    chk("async_rst_ready",   32'(instr_ready), 32'd1);
    #1 rst = 1'b0;
    instr_valid = 1'b1; instr = I_LD;
    step();
    chk("first_hs_state",   32'(state),   32'b00001);
    chk("first_hs_done",    32'(done),    32'd1);
    chk("first_hs_instr_q", 32'(instr_q), 32'(I_LD));
    instr_valid = 1'b0;
    step();
    chk("first_hs_retired", 32'(retired),     32'd1);
    chk("first_hs_ready",   32'(instr_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      logic [39:0] act, exp;
      instr_valid = vt[i].vld;
      instr       = vt[i].ins;
      step();
      act = {state, instr_ready, done, alu_sub, illegal, retired, instr_q};
      exp = {vt[i].st, vt[i].rdy, vt[i].dn, vt[i].sub, vt[i].ill, vt[i].ret, vt[i].iq};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL vec%0d: got st=%b rdy=%b dn=%b sub=%b ill=%b ret=%0h iq=%0h expected st=%b rdy=%b dn=%b sub=%b ill=%b ret=%0h iq=%0h",
                 i, state, instr_ready, done, alu_sub, illegal, retired, instr_q,
                 vt[i].st, vt[i].rdy, vt[i].dn, vt[i].sub, vt[i].ill, vt[i].ret, vt[i].iq);
      end
    end
    exp_ret = 5;

    // Counter wrap: fill to all-ones with movs, then one more
    for (int k = exp_ret; k < (1 << CW) - 1; k++) begin
      instr_valid = 1'b1; instr = I_MOV;
      step();
      instr_valid = 1'b0;
      step();
    end
    chk("wrap_full", 32'(retired), 32'((1 << CW) - 1));
    instr_valid = 1'b1; instr = I_MOV;
    step();
    chk("wrap_mov_done", 32'(done), 32'd1);
    instr_valid = 1'b0;
    step();
    chk("wrap_zero", 32'(retired), 32'd0);

    // Opcode 111
    instr_valid = 1'b1; instr = I_B7;
    step();
`ifdef CTRL_SEQ_HALT_EN
    chk("halt_state",   32'(state),       32'b00110);
    chk("halt_ready",   32'(instr_ready), 32'd0);
    chk("halt_done",    32'(done),        32'd0);
    chk("halt_instr_q", 32'(instr_q),     32'(I_B7));
    instr = I_MOV;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("halt_hold", 32'({state, instr_ready}), 32'({5'b00110, 1'b0}));
    end
    chk("halt_retired", 32'(retired), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("halt_rst_state", 32'(state), 32'd0);
    #1 rst = 1'b0;
    instr_valid = 1'b0;
`else
    chk("op7_state",   32'(state),   32'd0);
    chk("op7_illegal", 32'(illegal), 32'd1);
    chk("op7_retired", 32'(retired), 32'd0);
    chk("op7_instr_q", 32'(instr_q), 32'(I_MOV));
    instr_valid = 1'b0;
    step();
    chk("op7_pulse_end", 32'(illegal), 32'd0);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
